spi_word_rx: RTL

SPI_WORD_RX -- requirements
Module: spi_word_rx

---
 rtl/spi_word_rx.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_word_rx.sv
// spi_word_rx: SPI mode-0 slave that assembles MSB-first words from mosi and
// emits each completed word with a sequential write address.
// cs, sck and mosi are asynchronous to clk. Each one passes through a
// 2-flop synchroniser and a history flop, and edges are detected on the
// synchronised values. clk must run at least 4x faster than sck.
// Optional feature: define SPI_WORD_RX_MISO_EN to build the transmit path
// (tx_data -> miso). Without it, miso and tx_load are held at 0.

module spi_word_rx #(
    parameter int WORD_WIDTH        = 16,
    parameter int ADDRESS_BUS_WIDTH = 12,
    parameter int START_ADDRESS     = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cs,
    input  logic                         sck,
    input  logic                         mosi,
    output logic                         miso,
    input  logic [WORD_WIDTH-1:0]        tx_data,
    output logic                         tx_load,
    output logic [WORD_WIDTH-1:0]        data,
    output logic [ADDRESS_BUS_WIDTH-1:0] address,
    output logic                         write_strobe,
    output logic                         frame_done,
    output logic [15:0]                  word_count,
    output logic                         partial_word
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_W-1:0]             LAST_BIT   = CNT_W'(WORD_WIDTH - 1);
    localparam logic [CNT_W-1:0]             CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]             CNT_ZERO   = CNT_W'(0);
    localparam logic [ADDRESS_BUS_WIDTH-1:0] START_ADDR = ADDRESS_BUS_WIDTH'(START_ADDRESS);
    localparam logic [ADDRESS_BUS_WIDTH-1:0] ADDR_ONE   = ADDRESS_BUS_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // synchroniser and history flops
    logic cs_meta_r, cs_sync_r, cs_hist_r;
    logic sck_meta_r, sck_sync_r, sck_hist_r;
    logic mosi_meta_r, mosi_sync_r, unused_mosi_hist_r;

    // post-reset arming: a cs falling edge only counts once cs has really been seen high
    logic [2:0] valid_pipe_r;
    logic       armed_r;

    logic cs_fall_s, cs_rise_s, sck_rise_s;

    state_t state_r, state_s;
    logic   start_s, frame_end_s;

    logic [CNT_W-1:0]             bit_cnt_r;
    logic [WORD_WIDTH-1:0]        rx_shift_r;
    logic [ADDRESS_BUS_WIDTH-1:0] next_addr_r;
    logic [15:0]                  frame_cnt_r;

    logic                  shift_en_s, word_done_s, partial_s;
    logic [WORD_WIDTH-1:0] rx_next_s;
    logic [CNT_W-1:0]      bits_after_s;
    logic [15:0]           frame_cnt_inc_s, frame_total_s;

    logic [WORD_WIDTH-1:0]        data_r;
    logic [ADDRESS_BUS_WIDTH-1:0] address_r;
    logic                         write_strobe_r, frame_done_r, partial_word_r;
    logic [15:0]                  word_count_r;

    // Sample the asynchronous SPI pins into clk domain (2 sync flops + history).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_meta_r          <= 1'b1;
            cs_sync_r          <= 1'b1;
            cs_hist_r          <= 1'b1;
            sck_meta_r         <= 1'b0;
            sck_sync_r         <= 1'b0;
            sck_hist_r         <= 1'b0;
            mosi_meta_r        <= 1'b0;
            mosi_sync_r        <= 1'b0;
            unused_mosi_hist_r <= 1'b0;
        end else begin
            cs_meta_r          <= cs;
            cs_sync_r          <= cs_meta_r;
            cs_hist_r          <= cs_sync_r;
            sck_meta_r         <= sck;
            sck_sync_r         <= sck_meta_r;
            sck_hist_r         <= sck_sync_r;
            mosi_meta_r        <= mosi;
            mosi_sync_r        <= mosi_meta_r;
            unused_mosi_hist_r <= mosi_sync_r;
        end
    end

    // Arm frame start only after the sync pipe refills and cs is observed high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_pipe_r <= 3'b000;
            armed_r      <= 1'b0;
        end else begin
            valid_pipe_r <= {valid_pipe_r[1:0], 1'b1};
            if (valid_pipe_r[2] && cs_sync_r) begin
                armed_r <= 1'b1;
            end
        end
    end

    assign cs_fall_s  = armed_r & cs_hist_r & ~cs_sync_r;
    assign cs_rise_s  = ~cs_hist_r & cs_sync_r;
    assign sck_rise_s = ~sck_hist_r & sck_sync_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: cs low selects SHIFT, cs high returns to IDLE.
    always_comb begin
        state_s     = state_r;
        start_s     = 1'b0;
        frame_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_s = ST_SHIFT;
                    start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    state_s     = ST_IDLE;
                    frame_end_s = 1'b1;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Receive-side combinational helpers: shifted word, bit count after this cycle, frame totals.
    always_comb begin
        shift_en_s  = (state_r == ST_SHIFT) && sck_rise_s;
        word_done_s = shift_en_s && (bit_cnt_r == LAST_BIT);
        rx_next_s   = {rx_shift_r[WORD_WIDTH-2:0], mosi_sync_r};
        if (word_done_s) begin
            bits_after_s = CNT_ZERO;
        end else if (shift_en_s) begin
            bits_after_s = bit_cnt_r + CNT_ONE;
        end else begin
            bits_after_s = bit_cnt_r;
        end
        // a word finishing in the same cycle as cs rising counts as complete
        partial_s = frame_end_s && (bits_after_s != CNT_ZERO);
        if (frame_cnt_r == 16'hFFFF) begin
            frame_cnt_inc_s = frame_cnt_r;
        end else begin
            frame_cnt_inc_s = frame_cnt_r + 16'd1;
        end
        if (word_done_s) begin
            frame_total_s = frame_cnt_inc_s;
        end else begin
            frame_total_s = frame_cnt_r;
        end
    end

    // Receive datapath: bit counter, shift register, next address, frame word counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_r   <= CNT_ZERO;
            rx_shift_r  <= {WORD_WIDTH{1'b0}};
            next_addr_r <= START_ADDR;
            frame_cnt_r <= 16'd0;
        end else if (start_s) begin
            bit_cnt_r   <= CNT_ZERO;
            rx_shift_r  <= {WORD_WIDTH{1'b0}};
            next_addr_r <= START_ADDR;
            frame_cnt_r <= 16'd0;
        end else if (shift_en_s) begin
            bit_cnt_r  <= bits_after_s;
            rx_shift_r <= rx_next_s;
            if (word_done_s) begin
                next_addr_r <= next_addr_r + ADDR_ONE;
                frame_cnt_r <= frame_cnt_inc_s;
            end
        end
    end

    // Registered outputs: word/address publish, strobes and frame summary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r         <= {WORD_WIDTH{1'b0}};
            address_r      <= {ADDRESS_BUS_WIDTH{1'b0}};
            write_strobe_r <= 1'b0;
            frame_done_r   <= 1'b0;
            partial_word_r <= 1'b0;
            word_count_r   <= 16'd0;
        end else begin
            write_strobe_r <= word_done_s;
            frame_done_r   <= frame_end_s;
            partial_word_r <= partial_s;
            if (word_done_s) begin
                data_r    <= rx_next_s;
                address_r <= next_addr_r;
            end
            if (frame_end_s) begin
                word_count_r <= frame_total_s;
            end
        end
    end

    assign data         = data_r;
    assign address      = address_r;
    assign write_strobe = write_strobe_r;
    assign frame_done   = frame_done_r;
    assign partial_word = partial_word_r;
    assign word_count   = word_count_r;

`ifdef SPI_WORD_RX_MISO_EN
    logic [WORD_WIDTH-1:0] tx_shift_r, tx_shift_s;
    logic                  tx_load_r, miso_r, sck_fall_s;

    assign sck_fall_s = sck_hist_r & ~sck_sync_r;

    // Transmit register next value: load wins; the fall right after a word boundary keeps the fresh MSB.
    always_comb begin
        tx_shift_s = tx_shift_r;
        if (tx_load_r) begin
            tx_shift_s = tx_data;
        end else if ((state_r == ST_SHIFT) && sck_fall_s && (bit_cnt_r != CNT_ZERO)) begin
            tx_shift_s = {tx_shift_r[WORD_WIDTH-2:0], 1'b0};
        end else begin
            tx_shift_s = tx_shift_r;
        end
    end

    // Transmit registers; miso follows the next MSB so it lines up with the shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_load_r  <= 1'b0;
            tx_shift_r <= {WORD_WIDTH{1'b0}};
            miso_r     <= 1'b0;
        end else begin
            tx_load_r  <= start_s | word_done_s;
            tx_shift_r <= tx_shift_s;
            miso_r     <= (state_s == ST_SHIFT) ? tx_shift_s[WORD_WIDTH-1] : 1'b0;
        end
    end

    assign miso    = miso_r;
    assign tx_load = tx_load_r;
`else
    logic unused_tx_s;
    assign unused_tx_s = ^tx_data;
    assign miso        = 1'b0;
    assign tx_load     = 1'b0;
`endif

endmodule
